align_shifter: RTL and testbench

- Exponent-alignment stage directly downstream of the mantissa extender in the FP add/sub datapath.
- Takes two extended mantissas ({hidden, mantis, guard, round} format, MANTIS_SIZE+3 bits) and their biased exponents.
- Identifies the operand with the larger exponent and right-shifts the other operand's mantissa by the exponent difference, one bit per cycle, folding shifted-out bits into a sticky LSB.
- Uses valid/ready handshakes on both sides and holds one operation at a time.

---
 rtl/align_shifter.sv | 107 ++++++++++
 tb/tb_align_shifter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/align_shifter.sv
// Exponent-alignment stage: picks the larger-exponent operand and right-shifts the other
// one bit per cycle into a sticky LSB; one operation in flight, valid/ready on both sides.
module align_shifter #(
  parameter int EXP_SIZE    = 8,
  parameter int MANTIS_SIZE = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MANTIS_SIZE+2:0]   mantis_a,
  input  logic [MANTIS_SIZE+2:0]   mantis_b,
  input  logic [EXP_SIZE-1:0]      exp_a,
  input  logic [EXP_SIZE-1:0]      exp_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MANTIS_SIZE+2:0]   mantis_big,
  output logic [MANTIS_SIZE+2:0]   mantis_small,
  output logic [EXP_SIZE-1:0]      exp_out,
  output logic                     swap
);

  localparam int W     = MANTIS_SIZE + 3;
  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         big_q, big_d;
  logic [W-1:0]         small_q, small_d;
  logic [EXP_SIZE-1:0]  exp_q, exp_d;
  logic                 swap_q, swap_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 b_larger;
  logic [EXP_SIZE-1:0]  diff;
  logic [31:0]          diff_ext;
  logic [CNT_W-1:0]     cnt_in;

  always_comb begin
    b_larger = (exp_b > exp_a);
    diff     = b_larger ? (exp_b - exp_a) : (exp_a - exp_b);
    diff_ext = 32'(diff);
    // Shifting past the full width leaves only the sticky bit, so clamp at W.
    cnt_in   = (diff_ext > 32'(W)) ? CNT_W'(W) : CNT_W'(diff_ext);
  end

  always_comb begin
    state_d = state_q;
    big_d   = big_q;
    small_d = small_q;
    exp_d   = exp_q;
    swap_d  = swap_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          big_d   = b_larger ? mantis_b : mantis_a;
          small_d = b_larger ? mantis_a : mantis_b;
          exp_d   = b_larger ? exp_b : exp_a;
          swap_d  = b_larger;
          cnt_d   = cnt_in;
          state_d = (cnt_in == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        small_d = {1'b0, small_q[W-1:2], small_q[1] | small_q[0]};
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      big_q   <= '0;
      small_q <= '0;
      exp_q   <= '0;
      swap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      big_q   <= big_d;
      small_q <= small_d;
      exp_q   <= exp_d;
      swap_q  <= swap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign mantis_big   = big_q;
  assign mantis_small = small_q;
  assign exp_out      = exp_q;
  assign swap         = swap_q;

endmodule

// File: tb/tb_align_shifter.sv
// Bench for align_shifter: directed literal cases plus random traffic checked every cycle
// against a transaction-level model of the alignment stage.
module tb_align_shifter;

  localparam int E = 8;
  localparam int W = 26;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  mantis_a = '0;
  logic [W-1:0]  mantis_b = '0;
  logic [E-1:0]  exp_a = '0;
  logic [E-1:0]  exp_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  mantis_big;
  logic [W-1:0]  mantis_small;
  logic [E-1:0]  exp_out;
  logic          swap;

  int checks = 0;
  int errors = 0;

  align_shifter #(.EXP_SIZE(E), .MANTIS_SIZE(W-3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .mantis_a(mantis_a), .mantis_b(mantis_b),
    .exp_a(exp_a), .exp_b(exp_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .mantis_big(mantis_big), .mantis_small(mantis_small),
    .exp_out(exp_out), .swap(swap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Alignment as arithmetic: value >> n, with bit 0 forced on if any of bits n..0 were set.
  function automatic logic [W-1:0] align(input logic [W-1:0] v, input int n);
    logic [63:0] x;
    logic [63:0] mask;
    x = 64'(v);
    if (n == 0) return v;
    mask = (64'd1 << (n + 1)) - 64'd1;
    return W'((x >> n) | (((x & mask) != 64'd0) ? 64'd1 : 64'd0));
  endfunction

  // Transaction model: 0 idle, 1 busy aligning, 2 result presented.
  int            m_state = 0;
  int            m_wait = 0;
  logic [W-1:0]  m_big = '0, m_small = '0;
  logic [E-1:0]  m_exp = '0;
  logic          m_swap = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_wait  <= 0;
    end else begin
      case (m_state)
        0: if (in_valid) begin
          int d, n;
          logic sw;
          sw = (int'(exp_b) > int'(exp_a));
          d  = sw ? int'(exp_b) - int'(exp_a) : int'(exp_a) - int'(exp_b);
          n  = (d > W) ? W : d;
          m_swap  <= sw;
          m_big   <= sw ? mantis_b : mantis_a;
          m_small <= align(sw ? mantis_a : mantis_b, n);
          m_exp   <= sw ? exp_b : exp_a;
          m_wait  <= n;
          m_state <= (n == 0) ? 2 : 1;
        end
        1: begin
          m_wait <= m_wait - 1;
          if (m_wait == 1) m_state <= 2;
        end
        default: if (out_ready) m_state <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_big", 64'(mantis_big), 64'd0);
      chk("rst_small", 64'(mantis_small), 64'd0);
      chk("rst_exp", 64'(exp_out), 64'd0);
      chk("rst_swap", 64'(swap), 64'd0);
    end else begin
      chk("m_in_ready", 64'(in_ready), 64'(m_state == 0));
      chk("m_out_valid", 64'(out_valid), 64'(m_state == 2));
      if (m_state != 0) begin
        chk("m_big", 64'(mantis_big), 64'(m_big));
        chk("m_exp", 64'(exp_out), 64'(m_exp));
        chk("m_swap", 64'(swap), 64'(m_swap));
      end
      if (m_state == 2) chk("m_small", 64'(mantis_small), 64'(m_small));
    end
  end

  task automatic run_op(input logic [W-1:0] ma, input logic [W-1:0] mb,
                        input logic [E-1:0] ea, input logic [E-1:0] eb,
                        input logic [W-1:0] r_big, input logic [W-1:0] r_small,
                        input logic [E-1:0] r_exp, input logic r_swap, input int r_lat);
    int lat;
    @(negedge clk);
    mantis_a = ma; mantis_b = mb; exp_a = ea; exp_b = eb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mantis_a = W'($urandom); mantis_b = W'($urandom);
    exp_a = E'($urandom); exp_b = E'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("lit_latency", 64'(lat), 64'(r_lat));
    chk("lit_big", 64'(mantis_big), 64'(r_big));
    chk("lit_small", 64'(mantis_small), 64'(r_small));
    chk("lit_exp", 64'(exp_out), 64'(r_exp));
    chk("lit_swap", 64'(swap), 64'(r_swap));
    @(posedge clk);
    #1;
    chk("lit_valid_drop", 64'(out_valid), 64'd0);
    chk("lit_ready_back", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [W-1:0] held_small;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op(26'h2800000, 26'h2000000, 8'd127, 8'd127, 26'h2800000, 26'h2000000, 8'd127, 1'b0, 1);
    run_op(26'h2A00000, 26'h2000007, 8'd130, 8'd127, 26'h2A00000, 26'h0400001, 8'd130, 1'b0, 4);
    run_op(26'h0000003, 26'h3000000, 8'd10, 8'd11, 26'h3000000, 26'h0000001, 8'd11, 1'b1, 2);
    run_op(26'h3FFFFFF, 26'h2000000, 8'd250, 8'd50, 26'h3FFFFFF, 26'h0000001, 8'd250, 1'b0, 27);
    run_op(26'h3FFFFFF, 26'h0000000, 8'd250, 8'd50, 26'h3FFFFFF, 26'h0000000, 8'd250, 1'b0, 27);

    // Back-pressure: result must sit still while inputs churn.
    out_ready = 1'b0;
    @(negedge clk);
    mantis_a = 26'h1234567; mantis_b = 26'h2000003; exp_a = 8'd40; exp_b = 8'd42;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_valid", 64'(out_valid), 64'd1);
    held_small = mantis_small;
    chk("bp_small_lit", 64'(held_small), 64'h0000000 | 64'h1234567 >> 2 | 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      mantis_a = W'($urandom); mantis_b = W'($urandom);
      exp_a = E'($urandom); exp_b = E'($urandom);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_small", 64'(mantis_small), 64'(held_small));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drop", 64'(out_valid), 64'd0);
    chk("bp_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of a diff=10 alignment.
    @(negedge clk);
    mantis_a = 26'h3FFFFFF; mantis_b = 26'h2AAAAAA; exp_a = 8'd20; exp_b = 8'd10;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd1);
    chk("ar_big", 64'(mantis_big), 64'd0);
    chk("ar_small", 64'(mantis_small), 64'd0);
    chk("ar_exp", 64'(exp_out), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(26'h1111111, 26'h0F0F0F0, 8'd5, 8'd5, 26'h1111111, 26'h0F0F0F0, 8'd5, 1'b0, 1);

    // Random traffic with random stalls; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid = ($urandom % 3) != 0;
      out_ready = ($urandom % 4) != 0;
      mantis_a = W'($urandom);
      mantis_b = W'($urandom);
      exp_a = E'($urandom);
      if ($urandom % 2 == 0) exp_b = E'(int'(exp_a) + int'($urandom_range(0, 12)) - 6);
      else exp_b = E'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(negedge clk);
    chk("drain_idle", 64'(in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
